// File: rtl/sram_arbiter.sv
// sram_arbiter: three-requester round-robin arbiter for a single-port SRAM (AHB, array loader, activation writer).
// Latency: 4 edges minimum from req to the rsp_done/rsp_err pulse (grant, issue, ACCESS sampled, response).
// Backpressure: no grant while the SRAM is not FREE; WAIT holds until ACCESS/ERROR, or until TIMEOUT_CYC cycles when SRAM_ARB_TIMEOUT_EN is defined.
//
// Optional feature macro: SRAM_ARB_TIMEOUT_EN -- bounds the WAIT state with a TIMEOUT_CYC-cycle counter.
// Without it WAIT is unbounded and no counter is built.

module sram_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [2:0]            req,
    input  logic [2:0]            req_we,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            rsp_done,
    output logic [2:0]            rsp_err,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  arb_busy,
    output logic                  sram_read_en,
    output logic                  sram_write_en,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_write_data,
    input  logic [DATA_W-1:0]     sram_read_data,
    input  logic [1:0]            sram_state
);

    // SRAM status encodings that the FSM reacts to (01 BUSY simply keeps us waiting).
    localparam logic [1:0] SRAM_FREE   = 2'b00;
    localparam logic [1:0] SRAM_ACCESS = 2'b10;
    localparam logic [1:0] SRAM_ERROR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // A zero timeout would abort every access before the SRAM could answer.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sram_arbiter: TIMEOUT_CYC must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [1:0]          owner_q;       // requester that owns the current transaction
    logic                we_q;          // latched direction of the current transaction
    logic                err_q;         // current transaction ends with rsp_err
    logic [1:0]          last_grant_q;  // round-robin pointer, last requester answered
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_en_q;
    logic                wr_en_q;
    logic [2:0]          rsp_done_q;
    logic [2:0]          rsp_err_q;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int                TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0]             tmo_cnt_q;   // WAIT cycles already spent on this access
`endif

    // ------------------------------------------------------------------
    // Arbitration (combinational, evaluated every cycle, used only in IDLE)
    // ------------------------------------------------------------------
    logic [2:0]          eligible;
    logic [1:0]          rr_start;
    logic                win_vld;
    logic [1:0]          win_idx;
    logic [2:0]          cand_sum;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [2:0]          resp_vec_d;

    // A requester whose pulse is on the outputs this cycle is still holding
    // req (it only sees done/err now), so it sits out this one evaluation.
    assign eligible = req & ~(rsp_done_q | rsp_err_q);

    // Search begins one past the last requester served, wrapping 2 -> 0.
    assign rr_start = (last_grant_q == 2'd2) ? 2'd0 : (last_grant_q + 2'd1);

    // Round-robin pick: first eligible requester at or after rr_start.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = 2'd0;
        cand_sum = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand_sum = {1'b0, rr_start} + 3'(k);
            if (cand_sum >= 3'd3) begin
                cand_sum = cand_sum - 3'd3;
            end
            if (!win_vld && eligible[cand_sum[1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand_sum[1:0];
            end
        end
    end

    assign win_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_wdata = req_wdata[win_idx*DATA_W +: DATA_W];

    // One-hot of the owner, used for whichever response pulse fires.
    assign resp_vec_d = 3'b001 << owner_q;

    // ------------------------------------------------------------------
    // FSM with registered outputs: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'd0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            last_grant_q <= 2'd2;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            rsp_done_q   <= 3'b000;
            rsp_err_q    <= 3'b000;
`ifdef SRAM_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            // Strobes and response pulses are single-cycle unless set below.
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rsp_done_q <= 3'b000;
            rsp_err_q  <= 3'b000;

            case (state_q)
                ST_IDLE: begin
                    if (win_vld && (sram_state == SRAM_FREE)) begin
                        owner_q <= win_idx;
                        we_q    <= req_we[win_idx];
                        err_q   <= 1'b0;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        // Strobe goes high together with entry into ISSUE.
                        rd_en_q <= ~req_we[win_idx];
                        wr_en_q <= req_we[win_idx];
                        state_q <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // Strobe drops here; address/data stay on the bus.
                    state_q   <= ST_WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end

                ST_WAIT: begin
                    if (sram_state == SRAM_ACCESS) begin
                        if (!we_q) begin
                            rdata_q <= sram_read_data;
                        end
                        state_q <= ST_RESP;
                    end else if (sram_state == SRAM_ERROR) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
`ifdef SRAM_ARB_TIMEOUT_EN
                        // SRAM still FREE/BUSY: give up after TIMEOUT_CYC WAIT cycles.
                        if (tmo_cnt_q == TMO_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
`else
                        // SRAM still FREE/BUSY: keep waiting, no bound.
                        state_q <= ST_WAIT;
`endif
                    end
                end

                ST_RESP: begin
                    // Pulse goes out even if the owner already dropped req.
                    if (err_q) begin
                        rsp_err_q  <= resp_vec_d;
                    end else begin
                        rsp_done_q <= resp_vec_d;
                    end
                    last_grant_q <= owner_q;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign arb_busy        = (state_q != ST_IDLE);
    assign sram_read_en    = rd_en_q;
    assign sram_write_en   = wr_en_q;
    assign sram_addr       = addr_q;
    assign sram_write_data = wdata_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_done        = rsp_done_q;
    assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter (table vectors, hand sequences, random traffic).
// Drives requests and an SRAM status responder on the falling edge and samples there too.
// Expected owner/latency/data come from hand tables or a transaction-level round-robin model.

module tb_sram_arbiter;

    localparam int AW = 10;
    localparam int DW = 64;

    logic              clk;
    logic              n_rst;
    logic [2:0]        req;
    logic [2:0]        req_we;
    logic [3*AW-1:0]   req_addr;
    logic [3*DW-1:0]   req_wdata;
    logic [2:0]        rsp_done;
    logic [2:0]        rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic              arb_busy;
    logic              sram_read_en;
    logic              sram_write_en;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_write_data;
    logic [DW-1:0]     sram_read_data;
    logic [1:0]        sram_state;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(64)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .req             (req),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_done        (rsp_done),
        .rsp_err         (rsp_err),
        .rsp_rdata       (rsp_rdata),
        .arb_busy        (arb_busy),
        .sram_read_en    (sram_read_en),
        .sram_write_en   (sram_write_en),
        .sram_addr       (sram_addr),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_state      (sram_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model state: who was served last, what rsp_rdata holds.
    logic [1:0]    m_last;
    logic [DW-1:0] m_rdata;

    typedef struct {
        logic [2:0]      req;
        logic [2:0]      we;
        logic [3*AW-1:0] addr;
        logic [3*DW-1:0] wdata;
        int              pre;   // cycles SRAM is BUSY before it turns FREE
        int              wt;    // BUSY samples in WAIT before the final status
        logic [1:0]      fin;   // final SRAM status: 10 ACCESS or 11 ERROR
        logic [DW-1:0]   rd;    // read data presented with the final status
        bit              drop;  // requester drops req during WAIT
        bit              keep;  // requester still holds req in its response cycle
        logic [1:0]      own;   // expected winner
        bit              err;   // expected error response
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] we,
                                input logic [3*AW-1:0] a, input logic [3*DW-1:0] d,
                                input int pre, input int wt, input logic [1:0] fin,
                                input logic [DW-1:0] rd, input bit drop, input bit keep,
                                input logic [1:0] own, input bit err);
        vec_t v;
        v.req = r;   v.we = we;     v.addr = a;     v.wdata = d;
        v.pre = pre; v.wt = wt;     v.fin = fin;    v.rd = rd;
        v.drop = drop; v.keep = keep; v.own = own;  v.err = err;
        return v;
    endfunction

    // Round-robin rule: first requesting index after the last one served.
    function automatic logic [1:0] model_owner(input logic [2:0] r, input logic [1:0] last);
        int idx;
        for (int k = 1; k <= 3; k++) begin
            idx = (int'(last) + k) % 3;
            if (r[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    // Runs one transaction starting at a falling edge and checks it end to end.
    task automatic run_txn(input vec_t v, input int exp_lat, input string nm);
        int            o;
        logic [2:0]    oh;
        logic [DW-1:0] exp_rd;
        int            lat;
        bit            seen;
        int            rem;
        o      = int'(v.own);
        oh     = 3'b001 << v.own;
        exp_rd = (!v.we[o] && !v.err) ? v.rd : m_rdata;

        req = v.req; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        sram_read_data = ~v.rd;
        sram_state = 2'b01;
        for (int i = 0; i < v.pre; i++) begin
            @(posedge clk); @(negedge clk);
            chk({nm, "_nogrant_busy"}, 64'(arb_busy), 64'd0);
            chk({nm, "_nogrant_strobe"}, 64'({sram_read_en, sram_write_en}), 64'd0);
        end
        sram_state = 2'b00;

        @(posedge clk); @(negedge clk);          // grant
        chk({nm, "_issue_busy"}, 64'(arb_busy), 64'd1);
        chk({nm, "_issue_strobe"}, 64'({sram_read_en, sram_write_en}), 64'({~v.we[o], v.we[o]}));
        chk({nm, "_issue_addr"}, 64'(sram_addr), 64'(v.addr[o*AW +: AW]));
        chk({nm, "_issue_wdata"}, sram_write_data, v.wdata[o*DW +: DW]);
        sram_state = 2'b01;

        @(posedge clk); @(negedge clk);          // issue done, now waiting
        chk({nm, "_wait_strobe"}, 64'({sram_read_en, sram_write_en}), 64'd0);
        chk({nm, "_wait_addr"}, 64'(sram_addr), 64'(v.addr[o*AW +: AW]));
        if (v.drop) req = 3'b000;
        rem = v.wt;
        if (rem == 0) begin sram_state = v.fin; sram_read_data = v.rd; end
        lat  = 2;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if ((rsp_done | rsp_err) != 3'b000) begin
                seen = 1'b1;
            end else begin
                if (rem > 0) rem--;
                if (rem == 0) begin sram_state = v.fin; sram_read_data = v.rd; end
            end
        end
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_done"}, 64'(rsp_done), v.err ? 64'd0 : 64'(oh));
        chk({nm, "_err"}, 64'(rsp_err), v.err ? 64'(oh) : 64'd0);
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
        chk({nm, "_resp_busy"}, 64'(arb_busy), 64'd0);

        if (!v.keep) req = 3'b000;
        sram_state = 2'b00;
        @(posedge clk); @(negedge clk);
        chk({nm, "_pulse_once"}, 64'({rsp_done, rsp_err}), 64'd0);
        chk({nm, "_rdata_hold"}, rsp_rdata, exp_rd);
        chk({nm, "_no_regrant"}, 64'(arb_busy), 64'd0);

        m_last  = v.own;
        m_rdata = exp_rd;
    endtask

    vec_t tbl[9];

    initial begin
        vec_t        v;
        logic [31:0] t;
        logic [31:0] u;

        n_rst = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        sram_read_data = '0; sram_state = 2'b00;
        m_last = 2'd2; m_rdata = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(arb_busy), 64'd0);
        chk("rst_strobes", 64'({sram_read_en, sram_write_en}), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_wdata", sram_write_data, 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_pulses", 64'({rsp_done, rsp_err}), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // ---------------- table-driven vectors ----------------
        //            req     we      addr {l2,l1,l0}                     wdata {l2,l1,l0}                                                   pre wt fin    rd                      drop keep own err
        tbl[0] = mk(3'b001, 3'b001, {10'h0A1, 10'h0B1, 10'h005}, {64'h2222, 64'h1111, 64'hDEADBEEF},                         0, 0, 2'b10, 64'h1111_0000_1111_0000, 0, 0, 2'd0, 0);
        tbl[1] = mk(3'b010, 3'b000, {10'h0A2, 10'h3FF, 10'h0C2}, {64'h3, 64'h2, 64'h1},                                      0, 0, 2'b10, 64'h0123456789ABCDEF,    0, 0, 2'd1, 0);
        tbl[2] = mk(3'b001, 3'b000, {10'h011, 10'h022, 10'h033}, {64'hA, 64'hB, 64'hC},                                      3, 2, 2'b10, 64'hA5A5_A5A5_A5A5_A5A5, 0, 0, 2'd0, 0);
        tbl[3] = mk(3'b100, 3'b100, {10'h2F0, 10'h044, 10'h055}, {64'hFEED_F00D_0000_0001, 64'h5, 64'h6},                    0, 1, 2'b11, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 2'd2, 1);
        tbl[4] = mk(3'b110, 3'b000, {10'h066, 10'h077, 10'h088}, {64'h7, 64'h8, 64'h9},                                      0, 0, 2'b11, 64'h5555_6666_7777_8888, 0, 0, 2'd1, 1);
        tbl[5] = mk(3'b011, 3'b000, {10'h099, 10'h1AA, 10'h1BB}, {64'h10, 64'h11, 64'h12},                                   0, 3, 2'b10, 64'hCAFE_BABE_1234_5678, 1, 0, 2'd0, 0);
        tbl[6] = mk(3'b100, 3'b000, {10'h1CC, 10'h1DD, 10'h1EE}, {64'h13, 64'h14, 64'h15},                                   0, 0, 2'b10, 64'h0F0F_0F0F_F0F0_F0F0, 0, 1, 2'd2, 0);
        tbl[7] = mk(3'b100, 3'b000, {10'h201, 10'h202, 10'h203}, {64'h16, 64'h17, 64'h18},                                   0, 1, 2'b10, 64'h7777_0000_7777_0001, 0, 0, 2'd2, 0);
        tbl[8] = mk(3'b111, 3'b111, {10'h301, 10'h302, 10'h303}, {64'h1000_0002, 64'h1000_0001, 64'h1000_0000},              0, 0, 2'b10, 64'h9999_9999_9999_9999, 0, 0, 2'd0, 0);
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i], 4 + tbl[i].wt, $sformatf("vec%0d", i));
        end

        // ---------------- reset during WAIT ----------------
        req = 3'b010; req_we = 3'b000;
        req_addr = {10'h000, 10'h155, 10'h000}; req_wdata = '0;
        sram_state = 2'b00;
        @(posedge clk); @(negedge clk);
        sram_state = 2'b01;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("rstw_busy_before", 64'(arb_busy), 64'd1);
        n_rst = 1'b0;
        #1;
        chk("rstw_busy", 64'(arb_busy), 64'd0);
        chk("rstw_addr", 64'(sram_addr), 64'd0);
        chk("rstw_wdata", sram_write_data, 64'd0);
        chk("rstw_rdata", rsp_rdata, 64'd0);
        chk("rstw_strobes_pulses", 64'({sram_read_en, sram_write_en, rsp_done, rsp_err}), 64'd0);
        req = 3'b000; sram_state = 2'b00;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        m_last = 2'd2; m_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rstw_no_pulse", 64'({rsp_done, rsp_err, arb_busy}), 64'd0);
        end

        // ---------------- all requesting: order 0,1,2,0 from reset ----------------
        begin
            logic [1:0] order [4];
            order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
            for (int i = 0; i < 4; i++) begin
                v = mk(3'b111, 3'b000, {10'h3A0, 10'h3B0, 10'h3C0}, {64'h0, 64'h0, 64'h0},
                       0, i, 2'b10, 64'h4000_0000_0000_0000 + 64'(i), 0, 0, order[i], 0);
                run_txn(v, 4 + i, $sformatf("rr%0d", i));
            end
        end

`ifdef SRAM_ARB_TIMEOUT_EN
        // ---------------- SRAM stuck BUSY: timeout abort ----------------
        v = mk(3'b001, 3'b000, {10'h0, 10'h0, 10'h077}, {64'h0, 64'h0, 64'h0},
               0, 100000, 2'b10, 64'h1, 0, 0, model_owner(3'b001, m_last), 1);
        run_txn(v, 3 + 64, "timeout");
`endif

        // ---------------- random traffic against the model ----------------
        for (int n = 0; n < 40; n++) begin
            t = $urandom;
            u = $urandom;
            v.req   = 3'($urandom_range(1, 7));
            v.we    = t[2:0];
            v.addr  = {u[9:0], t[29:20], t[19:10]};
            v.wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            v.pre   = int'($urandom_range(0, 1));
            v.wt    = int'($urandom_range(0, 4));
            v.fin   = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
            v.rd    = {$urandom, $urandom};
            v.drop  = u[31];
            v.keep  = 1'b0;
            v.own   = model_owner(v.req, m_last);
            v.err   = (v.fin == 2'b11);
            run_txn(v, 4 + v.wt, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global bound so a stuck run still ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 64, SRAM word width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, cycles in WAIT before a timeout abort (used only when the timeout feature is compiled in).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, as the first ports below: clk  in  1  rising-edge clock.
REQ-005 SHALL have port n_rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  3  access request per requester; 0=AHB, 1=array loader, 2=activation writer.
REQ-007 SHALL have port req_we  in  3  per-requester write (1) / read (0).
REQ-008 SHALL have port req_addr  in  3*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_wdata  in  3*DATA_W  packed write data, packed the same way as req_addr.
REQ-010 SHALL have port rsp_done  out  3  one-cycle completion pulse per requester.
REQ-011 SHALL have port rsp_err  out  3  one-cycle error pulse per requester.
REQ-012 SHALL have port rsp_rdata  out  DATA_W  read data, valid while rsp_done is high.
REQ-013 SHALL have port arb_busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 SHALL have port sram_read_en  out  1  SRAM read strobe.
REQ-015 SHALL have port sram_write_en  out  1  SRAM write strobe.
REQ-016 SHALL have port sram_addr  out  ADDR_W  SRAM address.
REQ-017 SHALL have port sram_write_data  out  DATA_W  SRAM write data.
REQ-018 SHALL have port sram_read_data  in  DATA_W  SRAM read data.
REQ-019 SHALL have port sram_state  in  2  SRAM status: 00 FREE, 01 BUSY, 10 ACCESS (complete, data valid), 11 ERROR.

Function
REQ-020 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-021 In IDLE, SHALL move to ISSUE only when req is non-zero and sram_state==00; it SHALL latch the winner index, we, addr and wdata at that edge.
REQ-022 SHALL arbitrate round-robin: search starts at last_grant+1 mod 3, and the first asserted req wins.
REQ-023 In ISSUE, SHALL drive sram_read_en or sram_write_en (per the latched we) high for exactly one cycle, with sram_addr and sram_write_data held from the latch; it SHALL then go to WAIT.
REQ-024 In WAIT, sram_state 10 SHALL latch sram_read_data into rsp_rdata (reads only) and go to RESP; 11 SHALL go to RESP flagged as error; 00 or 01 SHALL remain in WAIT.
REQ-025 In RESP, SHALL pulse exactly one of rsp_done[g] or rsp_err[g] for one cycle, update last_grant=g, and return to IDLE.
REQ-026 Minimum latency, req to rsp_done, SHALL be 4 edges: grant, issue, ACCESS sampled, response.
REQ-027 Requesters hold req and payload until their done/err; if req drops mid-transaction, the transaction SHALL still complete and the pulse SHALL still be issued.
REQ-028 SHALL not re-grant the same requester in the cycle of its response; the earliest re-grant is the next IDLE evaluation.
REQ-029 sram_addr and sram_write_data SHALL hold their last latched value outside ISSUE; both strobes SHALL be 0 outside ISSUE.
REQ-030 rsp_rdata SHALL hold its value until the next successful read.

Reset
REQ-031 On n_rst low, asynchronously: FSM=IDLE, last_grant=2 (requester 0 first), all outputs 0, timeout counter 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no done/err pulse.

Configuration
REQ-033 With SRAM_ARB_TIMEOUT_EN defined, a counter SHALL run while in WAIT; at TIMEOUT_CYC consecutive WAIT cycles the FSM SHALL go to RESP flagged as error (rsp_err pulse).
REQ-034 Without SRAM_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, with no counter logic.

Verification
REQ-035 req=001, we=1, addr=0x005, wdata=0xDEADBEEF, state goes 10 one cycle after ISSUE -> one write_en pulse at addr 0x005 with that data, then rsp_done=001 after 4 edges total.
REQ-036 req=010 read at addr 0x3FF, sram_read_data=0x0123456789ABCDEF with state 10 -> rsp_rdata=0x0123456789ABCDEF while rsp_done=010.
REQ-037 req=111 held, state returns 10 each time -> grant order 0,1,2,0.
REQ-038 sram_state=01 held while req=001 -> no grant, arb_busy=0; release to 00 -> grant next edge.
REQ-039 WAIT with state 11 -> rsp_err pulse for the owner, no rsp_done; with SRAM_ARB_TIMEOUT_EN and state stuck 01 -> rsp_err after 64 WAIT cycles.
REQ-040 n_rst low during WAIT -> all outputs 0 at once, no response pulse, next req served from requester 0.
